// File: rtl/vga_uart_pkg.sv
// Shared constants for the UART-driven VGA framebuffer path:
// command bytes, default VRAM size and the loader FSM state encoding.
package vga_uart_pkg;

    localparam logic [7:0] CMD_ADDR  = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h5A;
    localparam logic [7:0] CMD_FILL  = 8'hC3;

    // 10 words per row x 60 rows, eight 2-bit pixels per word
    localparam int WORDS_DEFAULT = 600;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        FILL_HI = 3'd5,
        FILL_LO = 3'd6,
        FILLING = 3'd7
    } state_e;

endpackage

// File: rtl/vram_loader_if.sv
// Pin bundle for the loader: UART byte stream in, VRAM write port out.
// The master side feeds bytes and watches the write port; the slave side
// is the loader itself.
interface vram_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [15:0]       vram_data;
    logic [ADDR_W-1:0] vram_wraddr;
    logic              vram_wren;
    logic              busy;
    logic              err;

    modport master (
        output rx_data, rx_valid,
        input  vram_data, vram_wraddr, vram_wren, busy, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output vram_data, vram_wraddr, vram_wren, busy, err
    );
endinterface

// File: rtl/vram_loader.sv
// Byte-command VRAM loader. Decodes a UART byte stream into single-word
// writes (0x5A hi lo), address loads (0xA5 hi lo) and whole-screen fills
// (0xC3 hi lo). Every output is a register; RX bytes only ever reach the
// outputs through the next-state logic.
// Handshake: RX_DATA is consumed on every cycle RX_VALID=1 unless BUSY=1,
// in which case the byte is dropped with no effect. There is no back-pressure.
module vram_loader
    import vga_uart_pkg::*;
#(
    parameter int WORDS  = WORDS_DEFAULT,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic [15:0]       VRAM_DATA,
    output logic [ADDR_W-1:0] VRAM_WRADDR,
    output logic              VRAM_WREN,
    output logic              BUSY,
    output logic              ERR
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // current write address
    logic [ADDR_W-1:0] cnt_q, cnt_d;       // next fill address
    logic [1:0]        ahi_q, ahi_d;       // captured address bits [9:8]
    logic [7:0]        hi_q, hi_d;         // captured data/fill high byte
    logic [15:0]       fill_q, fill_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] new_addr;

    assign new_addr    = ADDR_W'({ahi_q, RX_DATA});
    assign VRAM_DATA   = data_q;
    assign VRAM_WRADDR = wraddr_q;
    assign VRAM_WREN   = wren_q;
    assign BUSY        = busy_q;
    assign ERR         = err_q;

    // Next-state decode: fill sweep first, then the BUSY tail, then byte commands.
    // The FILL_LO byte itself issues the write to address 0 so that BUSY and
    // WREN are both high for exactly WORDS cycles starting the next cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        ahi_d    = ahi_q;
        hi_d     = hi_q;
        fill_d   = fill_q;
        data_d   = data_q;
        wraddr_d = wraddr_q;
        wren_d   = 1'b0;
        busy_d   = busy_q;
        err_d    = 1'b0;

        if (state_q == FILLING) begin
            wren_d   = 1'b1;
            wraddr_d = cnt_q;
            data_d   = fill_q;
            busy_d   = 1'b1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                addr_d  = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end else if (busy_q) begin
            // last fill write is on the bus; bytes arriving now are dropped
            busy_d = 1'b0;
        end else if (RX_VALID) begin
            case (state_q)
                IDLE: begin
                    case (RX_DATA)
                        CMD_ADDR:  state_d = ADDR_HI;
                        CMD_WRITE: state_d = DATA_HI;
                        CMD_FILL:  state_d = FILL_HI;
                        default:   err_d   = 1'b1;
                    endcase
                end
                ADDR_HI: begin
                    ahi_d   = RX_DATA[1:0];
                    state_d = ADDR_LO;
                end
                ADDR_LO: begin
                    if (new_addr <= LAST) begin
                        addr_d = new_addr;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                DATA_HI: begin
                    hi_d    = RX_DATA;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    wren_d   = 1'b1;
                    data_d   = {hi_q, RX_DATA};
                    wraddr_d = addr_q;
                    addr_d   = (addr_q == LAST) ? '0 : addr_q + ADDR_W'(1);
                    state_d  = IDLE;
                end
                FILL_HI: begin
                    hi_d    = RX_DATA;
                    state_d = FILL_LO;
                end
                FILL_LO: begin
                    fill_d   = {hi_q, RX_DATA};
                    wren_d   = 1'b1;
                    wraddr_d = '0;
                    data_d   = {hi_q, RX_DATA};
                    busy_d   = 1'b1;
                    cnt_d    = ADDR_W'(1);
                    if (LAST == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FILLING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; reset aborts any command or fill in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            ahi_q    <= '0;
            hi_q     <= '0;
            fill_q   <= '0;
            data_q   <= '0;
            wraddr_q <= '0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ahi_q    <= ahi_d;
            hi_q     <= hi_d;
            fill_q   <= fill_d;
            data_q   <= data_d;
            wraddr_q <= wraddr_d;
            wren_q   <= wren_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/vram_loader.md
VRAM_LOADER -- requirements
Module: vram_loader

Interface
REQ-001 SHALL have parameter WORDS, default 600, meaning number of VRAM words (10 words/row x 60 rows).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning VRAM address width.
REQ-003 SHALL have port CLK  input  1  single clock; the write port of the VRAM is also on CLK.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port RX_DATA  input  8  received UART byte.
REQ-006 SHALL have port RX_VALID  input  1  one-cycle strobe qualifying RX_DATA.
REQ-007 SHALL have port VRAM_DATA  output  16  write word; eight 2-bit pixels, MSB pair leftmost.
REQ-008 SHALL have port VRAM_WRADDR  output  ADDR_W  write address.
REQ-009 SHALL have port VRAM_WREN  output  1  write strobe, one cycle per word.
REQ-010 SHALL have port BUSY  output  1  high while a fill is in progress.
REQ-011 SHALL have port ERR  output  1  one-cycle pulse on a protocol error.

Function
REQ-012 SHALL have states IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, FILL_HI, FILL_LO and FILLING.
REQ-013 SHALL advance state only on cycles with RX_VALID=1, except in FILLING.
REQ-014 SHALL, in IDLE, decode the command bytes as follows.
- 0xA5 -> ADDR_HI.
- 0x5A -> DATA_HI.
- 0xC3 -> FILL_HI.
- any other byte -> stay IDLE and pulse ERR.
REQ-015 SHALL, in ADDR_HI, capture RX_DATA[1:0] as address bits [9:8] and go to ADDR_LO.
REQ-016 SHALL, in ADDR_LO, load the assembled address into the current-address register if it is < WORDS; otherwise it SHALL keep the old address and pulse ERR; it SHALL return to IDLE in both cases.
REQ-017 SHALL, in DATA_HI, capture the data high byte and go to DATA_LO.
REQ-018 SHALL, on the DATA_LO byte, do all of the following.
- Assert VRAM_WREN on the next cycle with VRAM_DATA = {hi, lo} and VRAM_WRADDR = the current address.
- Then increment the current address.
- Return to IDLE.
REQ-019 SHALL wrap the address increment from WORDS-1 to 0.
REQ-020 SHALL, in FILL_HI and FILL_LO, capture the fill word the same way as DATA_HI and DATA_LO, then enter FILLING.
REQ-021 SHALL, in FILLING, write the fill word to address 0, 1, ..., WORDS-1.
- One write per cycle, starting the cycle after entry.
- VRAM_WREN is held high for exactly WORDS cycles.
REQ-022 SHALL then return to IDLE and set the current address to 0.
REQ-023 SHALL hold BUSY=1 from the cycle after the FILL_LO byte through the last fill write, inclusive.
REQ-024 SHALL ignore RX_VALID while BUSY=1, with no state change and no ERR.
REQ-025 SHALL hold VRAM_WREN=0 on all cycles other than those defined in REQ-018 and REQ-021.
REQ-026 SHALL register all outputs (no combinational path from RX_* to any output).
REQ-027 SHALL keep VRAM_DATA and VRAM_WRADDR at their last values when VRAM_WREN=0.
REQ-028 SHALL not apply any inter-byte timeout; a partial command waits indefinitely.

Reset
REQ-029 SHALL, while RST_N=0, immediately force all of the following.
- State to IDLE.
- Current address to 0.
- VRAM_DATA to 0, VRAM_WRADDR to 0.
- VRAM_WREN, BUSY and ERR to 0.
REQ-030 SHALL, on reset asserted mid-command or mid-fill, abort the operation with no further writes after RST_N rises.
REQ-031 SHALL leave already-written VRAM contents unaffected by reset.

Structure
REQ-032 SHALL take the command byte constants (CMD_ADDR=0xA5, CMD_WRITE=0x5A, CMD_FILL=0xC3), the WORDS default and the state enum from the shared package vga_uart_pkg.
REQ-033 SHALL be a single module with no sub-modules; the fill address counter is a register within the FSM.

Verification
REQ-034 SHALL cover: bytes A5 01 2C, then 5A FF 00 -> one WREN pulse with WRADDR=300 and DATA=0xFF00; the next 5A write goes to 301.
REQ-035 SHALL cover: address set to 599, then 5A 12 34 twice -> writes to 599 then 0.
REQ-036 SHALL cover: bytes A5 02 58 (address 600) -> ERR pulses once and the address is unchanged; byte 0x77 in IDLE -> ERR pulses once.
REQ-037 SHALL cover: bytes C3 55 AA -> BUSY high for 600 cycles and 600 consecutive WREN cycles at addresses 0..599 with DATA=0x55AA; RX bytes sent during BUSY cause no effect.
REQ-038 SHALL cover: RST_N pulsed low at fill cycle 100 -> outputs are 0 immediately, no WREN afterwards, and the next 5A 00 01 writes to address 0.
